div_ratio_sched: RTL and testbench

Run-time controller for the team's integer clock divider. It owns the divide counter and sequences all changes to it. Ratio changes arrive over a valid/ready handshake and take effect only at a divided-period boundary. Enable and disable are also applied only at period boundaries, so div_clk never glitches or produces a runt pulse. Odd ratios give 50 % duty using a negedge-retimed phase; even ratios give exact 50 % duty.

---
 rtl/div_ratio_sched.sv | 140 ++++++++++++++
 tb/tb_div_ratio_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/div_ratio_sched.sv
// div_ratio_sched: run-time controller for the integer clock divider.
// Owns the divide counter. Ratio changes and enable/disable requests are
// applied only at divided-period boundaries, so div_clk_o never glitches
// or produces a runt pulse. Odd ratios reach 50 % duty by OR-ing in a copy
// of the posedge phase that is retimed on the falling edge.
`timescale 1ns/1ps
module div_ratio_sched #(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             cfg_valid_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  output logic             cfg_ready_o,
  output logic             cfg_err_o,
  output logic [DIV_W-1:0] cur_div_o,
  output logic             period_start_o,
  output logic             div_clk_o
);

  typedef enum logic [1:0] {S_OFF, S_RUN, S_PEND} state_e;

  localparam logic [DIV_W-1:0] DEF_R = DIV_W'(DEF_DIV);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             p_q, p_d;
  logic             n_q;
  logic             ps_q, ps_d;
  logic             err_q, err_d;

  logic accept, cfg_bad, cfg_good, boundary;

  // A request can only be taken while no ratio is already waiting.
  assign cfg_ready_o = (state_q != S_PEND);
  assign accept      = cfg_valid_i & cfg_ready_o;
  assign cfg_bad     = accept & (cfg_div_i < DIV_W'(2));
  assign cfg_good    = accept & ~cfg_bad;
  // cur_div_q is never below 2, so the subtraction cannot wrap.
  assign boundary    = (cnt_q == (cur_div_q - DIV_W'(1)));

  // Next-state, counter, ratio and pulse logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_div_d = cur_div_q;
    pend_d    = pend_q;
    ps_d      = 1'b0;
    err_d     = cfg_bad;
    case (state_q)
      S_OFF: begin
        cnt_d = '0;
        if (cfg_good) cur_div_d = cfg_div_i;
        if (en_i) begin
          state_d = S_RUN;
          ps_d    = 1'b1;
        end
      end
      S_RUN: begin
        if (boundary) begin
          cnt_d = '0;
          if (en_i) begin
            ps_d = 1'b1;
            // A request landing on the boundary waits one full new period.
            if (cfg_good) begin
              state_d = S_PEND;
              pend_d  = cfg_div_i;
            end
          end else begin
            state_d = S_OFF;
            // Stopping anyway: the ratio can be applied directly.
            if (cfg_good) cur_div_d = cfg_div_i;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
          if (cfg_good) begin
            state_d = S_PEND;
            pend_d  = cfg_div_i;
          end
        end
      end
      S_PEND: begin
        if (boundary) begin
          cnt_d     = '0;
          cur_div_d = pend_q;
          if (en_i) begin
            state_d = S_RUN;
            ps_d    = 1'b1;
          end else begin
            state_d = S_OFF;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = S_OFF;
    endcase
    // High phase covers the first floor(N/2) counts of the period.
    p_d = (state_d != S_OFF) && (cnt_d < (cur_div_d >> 1));
  end

  // Posedge state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_OFF;
      cnt_q     <= '0;
      cur_div_q <= DEF_R;
      pend_q    <= '0;
      p_q       <= 1'b0;
      ps_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_div_q <= cur_div_d;
      pend_q    <= pend_d;
      p_q       <= p_d;
      ps_q      <= ps_d;
      err_q     <= err_d;
    end
  end

  // Half-cycle delayed copy of the phase, stretches odd-ratio high time.
  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) n_q <= 1'b0;
    else       n_q <= p_q;
  end

  // p and n are both low in the last count of any period, so the odd/even
  // select only ever changes while both inputs are zero.
  assign div_clk_o      = p_q | (n_q & cur_div_q[0]);
  assign cur_div_o      = cur_div_q;
  assign period_start_o = ps_q;
  assign cfg_err_o      = err_q;

endmodule

// File: tb/tb_div_ratio_sched.sv
// Directed bench for div_ratio_sched: start-up, ratio switch, bad requests,
// disable/re-enable, reset during a pending switch and a ratio sweep.
`timescale 1ns/1ps
module tb_div_ratio_sched;

  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic [DIV_W-1:0] cur_div;
  logic             period_start;
  logic             div_clk;

  int n_chk  = 0;
  int n_fail = 0;

  div_ratio_sched #(.DIV_W(DIV_W), .DEF_DIV(3)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_i          (en),
    .cfg_valid_i   (cfg_valid),
    .cfg_div_i     (cfg_div),
    .cfg_ready_o   (cfg_ready),
    .cfg_err_o     (cfg_err),
    .cur_div_o     (cur_div),
    .period_start_o(period_start),
    .div_clk_o     (div_clk)
  );

  always #5 clk = ~clk;

  // div_clk edge timing monitor (ns)
  int t_rise = 0, t_fall = 0;
  int hi_len = 0, lo_len = 0, per_len = 0, rise_cnt = 0;
  always @(posedge div_clk) begin
    per_len  <= int'($time) - t_rise;
    lo_len   <= int'($time) - t_fall;
    t_rise   <= int'($time);
    rise_cnt <= rise_cnt + 1;
  end
  always @(negedge div_clk) begin
    hi_len <= int'($time) - t_rise;
    t_fall <= int'($time);
  end

  // per-cycle event counters, sampled on the falling edge
  int ps_cnt = 0, rdy_lo_cnt = 0, err_cnt = 0;
  always @(negedge clk) begin
    if (period_start) ps_cnt     <= ps_cnt + 1;
    if (!cfg_ready)   rdy_lo_cnt <= rdy_lo_cnt + 1;
    if (cfg_err)      err_cnt    <= err_cnt + 1;
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Load ratio n while off, run four periods, stop, check timing.
  task automatic sweep(input int n);
    int base;
    cfg_valid = 1'b1;
    cfg_div   = DIV_W'(n);
    tick(1);
    chk("sweep_load", int'(cur_div), n);
    chk("sweep_err", int'(cfg_err), 0);
    cfg_valid = 1'b0;
    en        = 1'b1;
    base      = rise_cnt;
    tick(1);
    chk("sweep_ps", int'(period_start), 1);
    chk("sweep_rise", int'(div_clk), 1);
    tick(4 * n);
    chk("sweep_nrise", rise_cnt - base, 5);
    chk("sweep_per", per_len, 10 * n);
    chk("sweep_hi", hi_len, 5 * n);
    chk("sweep_lo", lo_len, 5 * n);
    en = 1'b0;
    tick(n);
    chk("sweep_off", int'(div_clk), 0);
  endtask

  initial begin
    int base;
    rst = 1'b1; en = 1'b1; cfg_valid = 1'b0; cfg_div = '0;
    // reset values, with en already requesting
    #3;
    chk("rst_div_clk", int'(div_clk), 0);
    chk("rst_ready", int'(cfg_ready), 1);
    chk("rst_err", int'(cfg_err), 0);
    chk("rst_ps", int'(period_start), 0);
    chk("rst_cur_div", int'(cur_div), 3);
    #5;  // t=8, past a posedge under reset
    chk("rst_hold", int'(div_clk), 0);
    #4;  // t=12
    rst = 1'b0;
    base = ps_cnt;
    tick(1);  // posedge 15: OFF -> RUN
    chk("start_ps", int'(period_start), 1);
    chk("start_rise_t", t_rise, 15);
    tick(9);  // t=106
    chk("n3_per", per_len, 30);
    chk("n3_hi", hi_len, 15);
    chk("n3_lo", lo_len, 15);
    chk("n3_ps_cnt", ps_cnt - base, 3);
    chk("n3_ps_now", int'(period_start), 1);

    // ratio 3 -> 4 requested at count 0
    cfg_valid = 1'b1; cfg_div = 8'd4;
    base = rdy_lo_cnt;
    tick(1);  // 116
    cfg_valid = 1'b0;
    chk("sw_ready_lo", int'(cfg_ready), 0);
    chk("sw_cur_old", int'(cur_div), 3);
    tick(2);  // 136
    chk("sw_cur_new", int'(cur_div), 4);
    chk("sw_ready_hi", int'(cfg_ready), 1);
    chk("sw_ps", int'(period_start), 1);
    chk("sw_old_per", per_len, 30);
    tick(1);  // 146
    chk("sw_rdy_cycles", rdy_lo_cnt - base, 2);
    tick(7);  // 216
    chk("n4_per", per_len, 40);
    chk("n4_hi", hi_len, 20);
    chk("n4_lo", lo_len, 20);

    // illegal ratios 1 and 0
    cfg_valid = 1'b1; cfg_div = 8'd1;
    base = err_cnt;
    tick(1);  // 226
    chk("err1_pulse", int'(cfg_err), 1);
    chk("err1_ready", int'(cfg_ready), 1);
    cfg_div = 8'd0;
    tick(1);  // 236
    chk("err0_pulse", int'(cfg_err), 1);
    cfg_valid = 1'b0;
    tick(1);  // 246
    chk("err_clear", int'(cfg_err), 0);
    chk("err_cur_div", int'(cur_div), 4);
    tick(1);  // 256
    chk("err_cnt", err_cnt - base, 2);
    chk("err_per", per_len, 40);

    // ratio 5, then disable at count 0
    cfg_valid = 1'b1; cfg_div = 8'd5;
    tick(1);  // 266
    cfg_valid = 1'b0;
    tick(3);  // 296: N=5 period began at 295
    chk("n5_cur", int'(cur_div), 5);
    chk("n5_ps", int'(period_start), 1);
    en = 1'b0;
    base = rise_cnt;
    tick(5);  // 346: off after boundary at 345
    chk("dis_hi", hi_len, 25);
    chk("dis_div_clk", int'(div_clk), 0);
    chk("dis_ps", int'(period_start), 0);
    tick(3);  // 376
    chk("dis_no_rise", rise_cnt - base, 0);
    en = 1'b1;
    tick(1);  // 386
    chk("re_ps", int'(period_start), 1);
    chk("re_rise_t", t_rise, 385);
    tick(5);  // 436
    chk("n5_per", per_len, 50);
    chk("n5_hi", hi_len, 25);
    chk("n5_lo", lo_len, 25);

    // reset during a pending 5 -> 7 switch
    cfg_valid = 1'b1; cfg_div = 8'd7;
    tick(1);  // 446
    cfg_valid = 1'b0;
    chk("pend_ready", int'(cfg_ready), 0);
    #2 rst = 1'b1;  // 448, mid high phase
    #1;
    chk("arst_div_clk", int'(div_clk), 0);
    chk("arst_cur_div", int'(cur_div), 3);
    chk("arst_ready", int'(cfg_ready), 1);
    chk("arst_ps", int'(period_start), 0);
    #2 rst = 1'b0;  // 451
    tick(1);  // 456
    chk("rerun_ps", int'(period_start), 1);
    tick(6);  // 516
    chk("rerun_cur", int'(cur_div), 3);
    chk("rerun_per", per_len, 30);

    en = 1'b0;
    tick(3);  // 546, off
    chk("off_div_clk", int'(div_clk), 0);
    sweep(2);
    sweep(3);
    sweep(254);
    sweep(255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
